// File: rtl/reg_bus_arb.sv
// reg_bus_arb: N-master to 1-slave register bus arbiter.
//
// Serialises register accesses from NUM_M masters onto a single register-bus
// slave. Each master holds m_req until it sees its one-hot m_ack pulse. Masters
// are served in round-robin order starting after the last master served.
// Every output comes straight from a flop.
//
// Optional feature (compile-time macro REG_BUS_ARB_ADDR_CHECK_EN):
//   When defined, a request whose address is >= ADDR_LIMIT is not forwarded to
//   the slave; it is acknowledged one cycle after the grant with m_err=1.
//   When undefined, no address check is made and m_err stays 0.
module reg_bus_arb #(
  parameter int NUM_M      = 2,
  parameter int REG_AW     = 8,
  parameter int REG_DW     = 8,
  parameter int RD_LAT     = 1,
  parameter int ADDR_LIMIT = 2 ** REG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_req,
  input  logic [NUM_M-1:0]          m_wr,
  input  logic [NUM_M*REG_AW-1:0]   m_addr,
  input  logic [NUM_M*REG_DW-1:0]   m_wdata,
  output logic [NUM_M-1:0]          m_ack,
  output logic [REG_DW-1:0]         m_rdata,
  output logic                      m_err,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [REG_AW-1:0]         s_addr,
  output logic [REG_DW-1:0]         s_wdata,
  input  logic [REG_DW-1:0]         s_rdata,
  output logic                      busy,
  output logic [$clog2(NUM_M)-1:0]  grant_id
);

  localparam int IW = $clog2(NUM_M);
  // Counter only ever holds RD_LAT-1 down to 0.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

`ifdef REG_BUS_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Unpacked per-master views of the packed address/data buses.
  logic [REG_AW-1:0] addr_arr  [NUM_M];
  logic [REG_DW-1:0] wdata_arr [NUM_M];

  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*REG_AW +: REG_AW];
      assign wdata_arr[gi] = m_wdata[gi*REG_DW +: REG_DW];
    end
  endgenerate

  state_t            state_q,      state_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [IW-1:0]     grant_q,      grant_d;
  logic [CW-1:0]     cnt_q,        cnt_d;
  logic              s_req_q,      s_req_d;
  logic              s_wr_q,       s_wr_d;
  logic [REG_AW-1:0] s_addr_q,     s_addr_d;
  logic [REG_DW-1:0] s_wdata_q,    s_wdata_d;
  logic [NUM_M-1:0]  m_ack_q,      m_ack_d;
  logic [REG_DW-1:0] m_rdata_q,    m_rdata_d;
  logic              m_err_q,      m_err_d;
  logic              busy_q,       busy_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;
  logic              addr_bad;

  // Round-robin pick: first requesting master after last_grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NUM_M);
      if (!pick_found && m_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Out-of-range address detection for the picked master (constant 0 when the
  // check is compiled out, so the error path folds away).
  always_comb begin
    addr_bad = ADDR_CHECK &&
               (64'(addr_arr[pick_idx]) >= 64'(ADDR_LIMIT));
  end

  // Next-state and next-output logic; pulses default low, bus fields hold.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    s_req_d      = 1'b0;
    s_wr_d       = s_wr_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    m_ack_d      = '0;
    m_rdata_d    = '0;
    m_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          if (addr_bad) begin
            // Rejected access: acknowledge straight away, slave untouched.
            state_d           = DONE;
            m_ack_d[pick_idx] = 1'b1;
            m_err_d           = 1'b1;
          end else begin
            // Latch the winner's fields directly into the slave-side flops;
            // they then stay put until the next issued access.
            state_d   = ISSUE;
            s_req_d   = 1'b1;
            s_wr_d    = m_wr[pick_idx];
            s_addr_d  = addr_arr[pick_idx];
            s_wdata_d = wdata_arr[pick_idx];
          end
        end
      end

      ISSUE: begin
        if (s_wr_q) begin
          state_d          = DONE;
          m_ack_d[grant_q] = 1'b1;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          // Slave data is valid exactly RD_LAT cycles after the s_req cycle.
          state_d          = DONE;
          m_ack_d[grant_q] = 1'b1;
          m_rdata_d        = s_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_M - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      s_req_q      <= 1'b0;
      s_wr_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      m_ack_q      <= '0;
      m_rdata_q    <= '0;
      m_err_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      s_req_q      <= s_req_d;
      s_wr_q       <= s_wr_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      m_ack_q      <= m_ack_d;
      m_rdata_q    <= m_rdata_d;
      m_err_q      <= m_err_d;
      busy_q       <= busy_d;
    end
  end

  assign m_ack    = m_ack_q;
  assign m_rdata  = m_rdata_q;
  assign m_err    = m_err_q;
  assign s_req    = s_req_q;
  assign s_wr     = s_wr_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_reg_bus_arb.sv
// tb_reg_bus_arb: self-checking bench for reg_bus_arb (NUM_M=3, 8/8 bits,
// RD_LAT=2). A transaction-level model predicts, per granted access, the cycle
// of s_req and of m_ack and the expected data; outputs are compared every cycle
// on the falling edge. Directed scenarios add literal expectations, then a long
// randomized run with occasional resets follows.
module tb_reg_bus_arb;
  localparam int NM = 3;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_req, m_wr;
  logic [23:0] m_addr, m_wdata;
  logic [2:0]  m_ack;
  logic [7:0]  m_rdata;
  logic        m_err, s_req, s_wr, busy;
  logic [7:0]  s_addr, s_wdata, s_rdata;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  reg_bus_arb #(.NUM_M(NM), .REG_AW(8), .REG_DW(8), .RD_LAT(RL), .ADDR_LIMIT('h80)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err), .s_req(s_req), .s_wr(s_wr),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .busy(busy), .grant_id(grant_id)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] slave_mem [256];
  logic [7:0] mirror    [256];
  bit         due_valid;
  int         due_cyc;
  logic [7:0] due_addr;

  // Model: the current (or most recent) transaction and its timeline.
  bit         t_valid, t_wr, t_err;
  int         t_start, t_issue, t_ack, t_gid;
  logic [7:0] t_addr, t_wdata, t_rdata;
  int         last_g;
  bit         rst_pend, cur_busy;
  logic       e_swr;
  logic [7:0] e_saddr, e_swdata;
  int         e_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare the current cycle against the model, then play slave and masters.
  task automatic observe();
    logic [7:0] e_rdata;
    logic [2:0] e_ack;
    logic       e_sreq, e_err, e_busy;
    if (rst_pend) begin
      t_valid = 0; e_swr = 0; e_saddr = 0; e_swdata = 0; e_gid = 0;
      last_g = NM - 1; due_valid = 0; rst_pend = 0;
    end
    if (t_valid && cyc == t_start) e_gid = t_gid;
    if (t_valid && cyc == t_issue) begin
      e_swr = t_wr; e_saddr = t_addr; e_swdata = t_wdata;
      if (t_wr) mirror[t_addr] = t_wdata;
      else t_rdata = mirror[t_addr];
    end
    e_busy   = t_valid && cyc >= t_start && cyc <= t_ack;
    cur_busy = e_busy;
    e_sreq   = t_valid && cyc == t_issue;
    e_ack    = 3'b000;
    if (t_valid && cyc == t_ack) e_ack[t_gid] = 1'b1;
    e_err    = (e_ack != 0) && t_err;
    e_rdata  = (e_ack != 0 && !t_wr && !t_err) ? t_rdata : 8'h00;

    chk("m_ack", m_ack, e_ack);
    chk("m_rdata", m_rdata, e_rdata);
    chk("m_err", m_err, e_err);
    chk("s_req", s_req, e_sreq);
    chk("s_wr", s_wr, e_swr);
    chk("s_addr", s_addr, e_saddr);
    chk("s_wdata", s_wdata, e_swdata);
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, e_gid);

    if (e_ack != 0)
      $display("txn cycle=%0d master=%0d %s addr=%02h data=%02h err=%0d",
               cyc, t_gid, t_wr ? "wr" : "rd", t_addr, t_wr ? t_wdata : e_rdata, e_err);

    // Slave: writes land at the s_req cycle, read data shows RL cycles later.
    if (s_req === 1'b1) begin
      if (s_wr) slave_mem[s_addr] = s_wdata;
      else begin due_valid = 1; due_cyc = cyc + RL; due_addr = s_addr; end
    end
    s_rdata = (due_valid && due_cyc == cyc) ? slave_mem[due_addr] : 8'($urandom);

    for (int i = 0; i < NM; i++) if (e_ack[i]) m_req[i] = 1'b0;
  endtask

  // Model decision for the coming edge, based on the inputs now driven.
  task automatic schedule();
    int idx;
    bit found;
    rst_pend = rst;
    found = 0;
    idx = 0;
    if (!rst && !cur_busy) begin
      for (int k = 1; k <= NM; k++) begin
        int c;
        c = (last_g + k) % NM;
        if (!found && m_req[c]) begin found = 1; idx = c; end
      end
    end
    if (found) begin
      t_valid = 1; t_gid = idx; t_wr = m_wr[idx];
      t_addr = m_addr[idx*8 +: 8]; t_wdata = m_wdata[idx*8 +: 8];
      t_err = 0;
`ifdef REG_BUS_ARB_ADDR_CHECK_EN
      t_err = (t_addr >= 8'h80);
`endif
      t_start = cyc + 1;
      if (t_err) begin t_issue = -1; t_ack = cyc + 1; end
      else begin t_issue = cyc + 1; t_ack = t_wr ? cyc + 2 : cyc + 2 + RL; end
      last_g = idx;
    end
  endtask

  task automatic advance();
    schedule();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic set_m(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
    m_req[i] = 1'b1; m_wr[i] = wr; m_addr[i*8 +: 8] = a; m_wdata[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    m_req = '0; rst = 1'b1; advance(); rst = 1'b0;
  endtask

  int order [6] = '{0, 1, 2, 0, 1, 2};
  int k3, nsreq, aidx;

  initial begin
    rst = 1'b1; m_req = '0; m_wr = '0; m_addr = '0; m_wdata = '0; s_rdata = '0;
    last_g = NM - 1; cur_busy = 0; rst_pend = 0; due_valid = 0; t_valid = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      slave_mem[i] = v; mirror[i] = v;
    end
    slave_mem[8'h20] = 8'h5C; mirror[8'h20] = 8'h5C;
    @(negedge clk);
    advance(); advance();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_sreq", s_req, 0);
    chk("rst_saddr", s_addr, 0);
    advance();

    // Single write from master 1.
    set_m(1, 1, 8'h10, 8'hA5); advance();
    chk("t1_sreq", s_req, 1); chk("t1_swr", s_wr, 1);
    chk("t1_saddr", s_addr, 8'h10); chk("t1_swdata", s_wdata, 8'hA5);
    chk("t1_noack", m_ack, 0);
    advance();
    chk("t1_ack", m_ack, 3'b010); chk("t1_rdata", m_rdata, 0); chk("t1_sreq_lo", s_req, 0);
    advance(); advance();

    // Single read from master 0; slave returns 0x5C.
    set_m(0, 0, 8'h20, 8'h00); advance();
    chk("t2_sreq", s_req, 1); chk("t2_swr", s_wr, 0); chk("t2_saddr", s_addr, 8'h20);
    advance(); chk("t2_noack2", m_ack, 0);
    advance(); chk("t2_noack3", m_ack, 0);
    advance(); chk("t2_ack", m_ack, 3'b001); chk("t2_rdata", m_rdata, 8'h5C);
    advance(); advance();

    // All three masters requesting continuously.
    do_reset();
    m_wr = 3'b111;
    k3 = 0; nsreq = 0;
    for (int n = 0; n < 80 && k3 < 6; n++) begin
      m_req = 3'b111;
      advance();
      if (s_req === 1'b1) nsreq++;
      if (m_ack != 0) begin
        chk("t3_onehot", $countones(m_ack), 1);
        aidx = 0;
        for (int i = 0; i < NM; i++) if (m_ack[i]) aidx = i;
        chk("t3_order", aidx, order[k3]);
        k3++;
      end
    end
    m_req = '0;
    chk("t3_count", k3, 6);
    chk("t3_sreqs", nsreq, 6);
    advance(); advance();

    // Reset during WAIT of a read, then master 2 alone.
    set_m(0, 0, 8'h33, 8'h00); advance(); advance();
    rst = 1'b1; m_req = '0; advance(); rst = 1'b0;
    chk("t4_ack", m_ack, 0); chk("t4_busy", busy, 0); chk("t4_saddr", s_addr, 0);
    chk("t4_grant", grant_id, 0); chk("t4_swr", s_wr, 0);
    set_m(2, 1, 8'h55, 8'h66); advance();
    chk("t4_noack", m_ack, 0); chk("t4_grant2", grant_id, 2); chk("t4_sreq", s_req, 1);
    advance(); chk("t4_ack2", m_ack, 3'b100);
    advance(); advance();

    // Master 2 arrives while master 0's read waits.
    set_m(0, 0, 8'h21, 8'h00); advance(); advance();
    set_m(2, 1, 8'h44, 8'h99); advance(); advance();
    chk("t5_ack0", m_ack, 3'b001);
    advance(); chk("t5_idle_sreq", s_req, 0); chk("t5_idle_busy", busy, 0);
    advance(); chk("t5_sreq", s_req, 1); chk("t5_saddr", s_addr, 8'h44); chk("t5_swdata", s_wdata, 8'h99);
    m_addr[16 +: 8] = 8'hEE; m_wdata[16 +: 8] = 8'h11;
    advance(); chk("t5_ack2", m_ack, 3'b100); chk("t5_hold_addr", s_addr, 8'h44); chk("t5_hold_wd", s_wdata, 8'h99);
    advance(); advance();

`ifdef REG_BUS_ARB_ADDR_CHECK_EN
    // Out-of-range read rejected, in-range read served.
    set_m(1, 0, 8'h90, 8'h00); advance();
    chk("t6_ack", m_ack, 3'b010); chk("t6_err", m_err, 1); chk("t6_rdata", m_rdata, 0); chk("t6_nosreq", s_req, 0);
    advance();
    set_m(1, 0, 8'h7F, 8'h00); advance();
    chk("t6_sreq", s_req, 1); chk("t6_saddr", s_addr, 8'h7F);
    advance(); advance(); advance();
    chk("t6_ack2", m_ack, 3'b010); chk("t6_err2", m_err, 0);
    advance();
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_req[i]) begin
          if ($urandom_range(3) == 0)
            set_m(i, 1'($urandom), 8'($urandom), 8'($urandom));
        end else begin
          if (!(cur_busy && t_gid == i) && $urandom_range(15) == 0) m_req[i] = 1'b0;
          if ($urandom_range(3) == 0) begin
            m_addr[i*8 +: 8]  = 8'($urandom);
            m_wdata[i*8 +: 8] = 8'($urandom);
          end
        end
      end
      rst = ($urandom_range(299) == 0);
      advance();
    end
    rst = 1'b0;
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

endmodule
